// File: rtl/display_code_monitor.sv
// Receiving end of the display interface: decodes the thermometer-coded
// level word, flags malformed words, debounces the alert bit into a
// confirmed alarm and keeps min/max level and alarm-entry statistics.
module display_code_monitor #(
    parameter int ALERT_DEBOUNCE = 3,
    parameter int CLEAR_DEBOUNCE = 4,
    parameter int EVT_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       coded_i,
    input  logic             alert_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic [3:0]       level_o,
    output logic             level_valid_o,
    output logic             code_error_o,
    output logic             alarm_o,
    output logic [3:0]       min_level_o,
    output logic [3:0]       max_level_o,
    output logic [EVT_W-1:0] alarm_events_o
);

    localparam logic [3:0] ALERT_TH = 4'(ALERT_DEBOUNCE);
    localparam logic [3:0] CLEAR_TH = 4'(CLEAR_DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE,
        NORMAL,
        PENDING,
        ALARM,
        RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cnt_inc;
    logic             enter_alarm;
    logic             well_formed;
    logic [3:0]       dec_level;
    logic             eff_alert;
    logic [3:0]       min_base, max_base;
    logic [EVT_W-1:0] evt_base;

    // Thermometer decode: only (1<<n)-1 for n=1..8 is a legal word
    always_comb begin
        well_formed = 1'b1;
        dec_level   = 4'd0;
        case (coded_i)
            8'h01:   dec_level = 4'd1;
            8'h03:   dec_level = 4'd2;
            8'h07:   dec_level = 4'd3;
            8'h0F:   dec_level = 4'd4;
            8'h1F:   dec_level = 4'd5;
            8'h3F:   dec_level = 4'd6;
            8'h7F:   dec_level = 4'd7;
            8'hFF:   dec_level = 4'd8;
            default: well_formed = 1'b0;
        endcase
    end

    // A malformed word is treated as an alert so a broken link fails safe
    assign eff_alert = alert_i | ~well_formed;
    assign cnt_inc   = cnt_q + 4'd1;

    // Debounce FSM next-state; only valid samples move it
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_alarm = 1'b0;
        if (valid_i) begin
            case (state_q)
                IDLE, NORMAL: begin
                    if (eff_alert) begin
                        if (ALERT_TH == 4'd1) begin
                            state_d     = ALARM;
                            cnt_d       = 4'd0;
                            enter_alarm = 1'b1;
                        end else begin
                            state_d = PENDING;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        state_d = NORMAL;
                        cnt_d   = 4'd0;
                    end
                end
                PENDING: begin
                    if (eff_alert) begin
                        if (cnt_inc >= ALERT_TH) begin
                            state_d     = ALARM;
                            cnt_d       = 4'd0;
                            enter_alarm = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = NORMAL;
                        cnt_d   = 4'd0;
                    end
                end
                ALARM: begin
                    if (!eff_alert) begin
                        if (CLEAR_TH == 4'd1) begin
                            state_d = NORMAL;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = RECOVER;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                RECOVER: begin
                    if (!eff_alert) begin
                        if (cnt_inc >= CLEAR_TH) begin
                            state_d = NORMAL;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ALARM;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Statistics start from reset values when cleared, so a same-cycle sample lands on top
    always_comb begin
        min_base = clear_i ? 4'hF : min_level_o;
        max_base = clear_i ? 4'h0 : max_level_o;
        evt_base = clear_i ? '0 : alarm_events_o;
    end

    // FSM state, debounce counter and registered alarm flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            alarm_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_o <= (state_d == ALARM) || (state_d == RECOVER);
        end
    end

    // Level capture, sticky error and statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_o        <= 4'd0;
            level_valid_o  <= 1'b0;
            code_error_o   <= 1'b0;
            min_level_o    <= 4'hF;
            max_level_o    <= 4'h0;
            alarm_events_o <= '0;
        end else begin
            level_valid_o  <= valid_i;
            code_error_o   <= (clear_i ? 1'b0 : code_error_o) | (valid_i & ~well_formed);
            min_level_o    <= min_base;
            max_level_o    <= max_base;
            alarm_events_o <= (enter_alarm && evt_base != '1) ? evt_base + 1'b1 : evt_base;
            if (valid_i && well_formed) begin
                level_o     <= dec_level;
                min_level_o <= (dec_level < min_base) ? dec_level : min_base;
                max_level_o <= (dec_level > max_base) ? dec_level : max_base;
            end
        end
    end

endmodule

// File: tb/tb_display_code_monitor.sv
// Directed bench for display_code_monitor: level decode, debounce,
// recovery, malformed words, clear, counter saturation and mid-debounce reset.
module tb_display_code_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] coded = 8'h00;
    logic       alert = 1'b0;
    logic       valid = 1'b0;
    logic       clear = 1'b0;

    logic [3:0] level, min_l, max_l;
    logic       lv, err, alarm;
    logic [7:0] evt;

    logic [3:0] level2, min_l2, max_l2;
    logic       lv2, err2, alarm2;
    logic [1:0] evt2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    display_code_monitor dut (
        .clk_i(clk), .rst_i(rst), .coded_i(coded), .alert_i(alert),
        .valid_i(valid), .clear_i(clear), .level_o(level), .level_valid_o(lv),
        .code_error_o(err), .alarm_o(alarm), .min_level_o(min_l),
        .max_level_o(max_l), .alarm_events_o(evt)
    );

    display_code_monitor #(.EVT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .coded_i(coded), .alert_i(alert),
        .valid_i(valid), .clear_i(clear), .level_o(level2), .level_valid_o(lv2),
        .code_error_o(err2), .alarm_o(alarm2), .min_level_o(min_l2),
        .max_level_o(max_l2), .alarm_events_o(evt2)
    );

    // One valid sample; returns at the negedge after the sampling edge
    task automatic drive(input logic [7:0] c, input logic a, input logic clr);
        @(negedge clk);
        coded = c; alert = a; valid = 1'b1; clear = clr;
        @(negedge clk);
        valid = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (lv !== 1'b0) begin fails++; $display("FAIL reset_lv got %b exp 0", lv); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL reset_alarm got %b exp 0", alarm); end
        checks++; if (min_l !== 4'hF) begin fails++; $display("FAIL reset_min got %h exp F", min_l); end
        checks++; if (max_l !== 4'h0) begin fails++; $display("FAIL reset_max got %h exp 0", max_l); end
        checks++; if (evt !== 8'd0) begin fails++; $display("FAIL reset_evt got %0d exp 0", evt); end
    endtask

    task automatic test_levels();
        logic [7:0] words [3];
        logic [3:0] exp_lv [3];
        words = '{8'h01, 8'hFF, 8'h0F};
        exp_lv = '{4'd1, 4'd8, 4'd4};
        for (int i = 0; i < 3; i++) begin
            drive(words[i], 1'b0, 1'b0);
            checks++; if (level !== exp_lv[i]) begin fails++; $display("FAIL level_%0d got %0d exp %0d", i, level, exp_lv[i]); end
            checks++; if (lv !== 1'b1) begin fails++; $display("FAIL lv_pulse_%0d got %b exp 1", i, lv); end
            @(negedge clk);
            checks++; if (lv !== 1'b0) begin fails++; $display("FAIL lv_drop_%0d got %b exp 0", i, lv); end
        end
        checks++; if (min_l !== 4'd1) begin fails++; $display("FAIL levels_min got %0d exp 1", min_l); end
        checks++; if (max_l !== 4'd8) begin fails++; $display("FAIL levels_max got %0d exp 8", max_l); end
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL levels_alarm got %b exp 0", alarm); end
    endtask

    task automatic test_alert_debounce();
        logic       al  [6];
        logic       exp [6];
        al  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(8'h03, al[i], 1'b0);
            checks++; if (alarm !== exp[i]) begin fails++; $display("FAIL debounce_alarm_%0d got %b exp %b", i, alarm, exp[i]); end
        end
        checks++; if (evt !== 8'd1) begin fails++; $display("FAIL debounce_evt got %0d exp 1", evt); end
    endtask

    task automatic test_recovery();
        logic al  [8];
        logic exp [8];
        al  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(8'h07, al[i], 1'b0);
            checks++; if (alarm !== exp[i]) begin fails++; $display("FAIL recover_alarm_%0d got %b exp %b", i, alarm, exp[i]); end
        end
        checks++; if (evt !== 8'd1) begin fails++; $display("FAIL recover_evt got %0d exp 1", evt); end
    endtask

    task automatic test_malformed();
        drive(8'h05, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL malformed_err got %b exp 1", err); end
        checks++; if (level !== 4'd3) begin fails++; $display("FAIL malformed_level got %0d exp 3", level); end
        checks++; if (lv !== 1'b1) begin fails++; $display("FAIL malformed_lv got %b exp 1", lv); end
        checks++; if (min_l !== 4'd1 || max_l !== 4'd8) begin fails++; $display("FAIL malformed_minmax got %0d/%0d exp 1/8", min_l, max_l); end
        drive(8'h05, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL malformed_alarm2 got %b exp 0", alarm); end
        drive(8'h05, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL malformed_alarm3 got %b exp 1", alarm); end
        checks++; if (evt !== 8'd2) begin fails++; $display("FAIL malformed_evt got %0d exp 2", evt); end
        drive(8'h03, 1'b0, 1'b1);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL clear_err got %b exp 0", err); end
        checks++; if (min_l !== 4'd2) begin fails++; $display("FAIL clear_min got %0d exp 2", min_l); end
        checks++; if (max_l !== 4'd2) begin fails++; $display("FAIL clear_max got %0d exp 2", max_l); end
        checks++; if (evt !== 8'd0) begin fails++; $display("FAIL clear_evt got %0d exp 0", evt); end
        checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL clear_alarm got %b exp 1", alarm); end
        checks++; if (level !== 4'd2) begin fails++; $display("FAIL clear_level got %0d exp 2", level); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            for (int k = 0; k < 3; k++) drive(8'h1F, 1'b1, 1'b0);
            for (int k = 0; k < 4; k++) drive(8'h1F, 1'b0, 1'b0);
            if (e == 3) begin
                checks++; if (evt2 !== 2'd3) begin fails++; $display("FAIL sat_evt2_at3 got %0d exp 3", evt2); end
            end
        end
        checks++; if (evt2 !== 2'd3) begin fails++; $display("FAIL sat_evt2 got %0d exp 3", evt2); end
        checks++; if (evt !== 8'd5) begin fails++; $display("FAIL sat_evt8 got %0d exp 5", evt); end
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL sat_alarm got %b exp 0", alarm); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h01, 1'b1, 1'b0);
        // reset wins over a concurrent third alert sample
        @(negedge clk);
        rst = 1'b1; coded = 8'h01; alert = 1'b1; valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL midrst_alarm got %b exp 0", alarm); end
        checks++; if (level !== 4'd0 || lv !== 1'b0) begin fails++; $display("FAIL midrst_level got %0d/%b exp 0/0", level, lv); end
        checks++; if (min_l !== 4'hF || max_l !== 4'h0) begin fails++; $display("FAIL midrst_minmax got %h/%h exp F/0", min_l, max_l); end
        checks++; if (evt !== 8'd0 || err !== 1'b0) begin fails++; $display("FAIL midrst_evt_err got %0d/%b exp 0/0", evt, err); end
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h01, 1'b1, 1'b0);
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL midrst_restart2 got %b exp 0", alarm); end
        drive(8'h01, 1'b1, 1'b0);
        checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL midrst_restart3 got %b exp 1", alarm); end
    endtask

    task automatic test_boundary();
        do_reset();
        drive(8'h80, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL bnd_80_err got %b exp 1", err); end
        checks++; if (level !== 4'd0 || min_l !== 4'hF) begin fails++; $display("FAIL bnd_80_hold got %0d/%h exp 0/F", level, min_l); end
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL bnd_clear_err got %b exp 0", err); end
        drive(8'h00, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL bnd_00_err got %b exp 1", err); end
        drive(8'h01, 1'b0, 1'b1);
        checks++; if (err !== 1'b0 || min_l !== 4'd1 || max_l !== 4'd1) begin fails++; $display("FAIL bnd_clr01 got %b/%0d/%0d exp 0/1/1", err, min_l, max_l); end
    endtask

    initial begin
        test_reset();
        test_levels();
        test_alert_debounce();
        test_recovery();
        test_malformed();
        test_saturate();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
